// File: rtl/fft_twiddle_mul_if.sv
// Sample/twiddle bus between the radix-4 butterfly, the twiddle ROM and the
// twiddle multiplier stage.
interface fft_twiddle_mul_if #(
    parameter int BIT    = 17,
    parameter int TW_BIT = 16,
    parameter int N_LOG2 = 10
);
    logic                     iSTART;
    logic [3:0]               iSTAGE;
    logic                     iVALID;
    logic signed [BIT-1:0]    iX0_RE, iX0_IM, iX1_RE, iX1_IM;
    logic signed [BIT-1:0]    iX2_RE, iX2_IM, iX3_RE, iX3_IM;
    logic [N_LOG2-1:0]        oTW_ADDR1, oTW_ADDR2, oTW_ADDR3;
    logic signed [TW_BIT-1:0] iW1_RE, iW1_IM, iW2_RE, iW2_IM, iW3_RE, iW3_IM;
    logic                     oVALID;
    logic signed [BIT-1:0]    oY0_RE, oY0_IM, oY1_RE, oY1_IM;
    logic signed [BIT-1:0]    oY2_RE, oY2_IM, oY3_RE, oY3_IM;
    logic                     oSPAN_DONE;

    // Upstream side: butterfly plus ROM data source.
    modport master (
        output iSTART, iSTAGE, iVALID,
        output iX0_RE, iX0_IM, iX1_RE, iX1_IM, iX2_RE, iX2_IM, iX3_RE, iX3_IM,
        output iW1_RE, iW1_IM, iW2_RE, iW2_IM, iW3_RE, iW3_IM,
        input  oTW_ADDR1, oTW_ADDR2, oTW_ADDR3,
        input  oVALID, oSPAN_DONE,
        input  oY0_RE, oY0_IM, oY1_RE, oY1_IM, oY2_RE, oY2_IM, oY3_RE, oY3_IM
    );

    // Twiddle multiplier side.
    modport slave (
        input  iSTART, iSTAGE, iVALID,
        input  iX0_RE, iX0_IM, iX1_RE, iX1_IM, iX2_RE, iX2_IM, iX3_RE, iX3_IM,
        input  iW1_RE, iW1_IM, iW2_RE, iW2_IM, iW3_RE, iW3_IM,
        output oTW_ADDR1, oTW_ADDR2, oTW_ADDR3,
        output oVALID, oSPAN_DONE,
        output oY0_RE, oY0_IM, oY1_RE, oY1_IM, oY2_RE, oY2_IM, oY3_RE, oY3_IM
    );
endinterface

// File: rtl/fft_twiddle_mul.sv
// Radix-4 DIF twiddle stage: generates ROM addresses from the span counter,
// multiplies Y1..Y3 by their twiddles (round + saturate), passes Y0 through.
// One quad per clock, 3-cycle latency.
module fft_twiddle_mul #(
    parameter int BIT    = 17,
    parameter int TW_BIT = 16,
    parameter int N_LOG2 = 10
) (
    input  logic             iCLK,
    input  logic             iRESET,
    fft_twiddle_mul_if.slave bus
);
    localparam int PW     = BIT + TW_BIT;
    localparam int SW     = PW + 1;
    localparam int NSTAGE = N_LOG2 / 2;
    localparam logic signed [SW-1:0] RND    = SW'(1) << (TW_BIT - 3);
    localparam logic signed [SW-1:0] SAT_HI = {{(SW-BIT+1){1'b0}}, {(BIT-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_LO = {{(SW-BIT+1){1'b1}}, {(BIT-1){1'b0}}};

    function automatic logic signed [BIT-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SAT_HI) return SAT_HI[BIT-1:0];
        if (v < SAT_LO) return SAT_LO[BIT-1:0];
        return v[BIT-1:0];
    endfunction

    logic [N_LOG2:0]   span_len;
    logic [N_LOG2-1:0] nmax, n_q, n_eff, m1, m2, m3;
    logic [4:0]        shamt;
    logic              last_in;

    logic signed [BIT-1:0]    xin_re [4], xin_im [4];
    logic signed [BIT-1:0]    x1_re [4], x1_im [4];
    logic signed [BIT-1:0]    y0d_re, y0d_im;
    logic signed [BIT-1:0]    y_re [4], y_im [4];
    logic signed [TW_BIT-1:0] w_re [1:3], w_im [1:3];
    logic signed [PW-1:0]     pp_rr_d [1:3], pp_ii_d [1:3], pp_ri_d [1:3], pp_ir_d [1:3];
    logic signed [PW-1:0]     pp_rr [1:3], pp_ii [1:3], pp_ri [1:3], pp_ir [1:3];
    logic signed [SW-1:0]     acc_re [1:3], acc_im [1:3];
    logic v1, v2, v3, l1, l2, l3;

    // Span length, effective index (iSTART forces 0 this cycle) and k*n mod N.
    always_comb begin
        span_len = {1'b1, {N_LOG2{1'b0}}} >> ({1'b0, bus.iSTAGE, 1'b0} + 6'd2);
        nmax     = '0;
        if (bus.iSTAGE < 4'(NSTAGE)) nmax = span_len[N_LOG2-1:0] - N_LOG2'(1);
        n_eff    = bus.iSTART ? '0 : n_q;
        last_in  = (n_eff == nmax);
        shamt    = {bus.iSTAGE, 1'b0};
        m1       = n_eff;
        m2       = n_eff << 1;
        m3       = n_eff + (n_eff << 1);
    end

    // Shifting inside N_LOG2 bits gives the mod-N wrap; shifts >= N_LOG2 yield 0.
    assign bus.oTW_ADDR1 = m1 << shamt;
    assign bus.oTW_ADDR2 = m2 << shamt;
    assign bus.oTW_ADDR3 = m3 << shamt;

    // Twiddle index counter n, wrapping at the end of each span.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET)          n_q <= '0;
        else if (bus.iVALID)  n_q <= last_in ? '0 : n_eff + N_LOG2'(1);
        else if (bus.iSTART)  n_q <= '0;
    end

    // Gather bus samples into arrays and form the partial products.
    always_comb begin
        xin_re[0] = bus.iX0_RE; xin_im[0] = bus.iX0_IM;
        xin_re[1] = bus.iX1_RE; xin_im[1] = bus.iX1_IM;
        xin_re[2] = bus.iX2_RE; xin_im[2] = bus.iX2_IM;
        xin_re[3] = bus.iX3_RE; xin_im[3] = bus.iX3_IM;
        w_re[1] = bus.iW1_RE; w_im[1] = bus.iW1_IM;
        w_re[2] = bus.iW2_RE; w_im[2] = bus.iW2_IM;
        w_re[3] = bus.iW3_RE; w_im[3] = bus.iW3_IM;
        for (int unsigned k = 1; k < 4; k++) begin
            pp_rr_d[k] = PW'(x1_re[k]) * PW'(w_re[k]);
            pp_ii_d[k] = PW'(x1_im[k]) * PW'(w_im[k]);
            pp_ri_d[k] = PW'(x1_re[k]) * PW'(w_im[k]);
            pp_ir_d[k] = PW'(x1_im[k]) * PW'(w_re[k]);
            acc_re[k]  = (SW'(pp_rr[k]) - SW'(pp_ii[k]) + RND) >>> (TW_BIT - 2);
            acc_im[k]  = (SW'(pp_ri[k]) + SW'(pp_ir[k]) + RND) >>> (TW_BIT - 2);
        end
    end

    // P1: capture the quad while the ROM fetches its twiddles.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            v1 <= 1'b0;
            l1 <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                x1_re[i] <= '0;
                x1_im[i] <= '0;
            end
        end else begin
            v1 <= bus.iVALID;
            l1 <= bus.iVALID & last_in;
            if (bus.iVALID) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    x1_re[i] <= xin_re[i];
                    x1_im[i] <= xin_im[i];
                end
            end
        end
    end

    // P2: register partial products against the ROM data; delay Y0.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            v2     <= 1'b0;
            l2     <= 1'b0;
            y0d_re <= '0;
            y0d_im <= '0;
            for (int unsigned k = 1; k < 4; k++) begin
                pp_rr[k] <= '0;
                pp_ii[k] <= '0;
                pp_ri[k] <= '0;
                pp_ir[k] <= '0;
            end
        end else begin
            v2 <= v1;
            l2 <= l1;
            if (v1) begin
                y0d_re <= x1_re[0];
                y0d_im <= x1_im[0];
                for (int unsigned k = 1; k < 4; k++) begin
                    pp_rr[k] <= pp_rr_d[k];
                    pp_ii[k] <= pp_ii_d[k];
                    pp_ri[k] <= pp_ri_d[k];
                    pp_ir[k] <= pp_ir_d[k];
                end
            end
        end
    end

    // P3: round, saturate and hold the output quad between valid cycles.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            v3 <= 1'b0;
            l3 <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                y_re[i] <= '0;
                y_im[i] <= '0;
            end
        end else begin
            v3 <= v2;
            l3 <= l2;
            if (v2) begin
                y_re[0] <= y0d_re;
                y_im[0] <= y0d_im;
                for (int unsigned k = 1; k < 4; k++) begin
                    y_re[k] <= sat(acc_re[k]);
                    y_im[k] <= sat(acc_im[k]);
                end
            end
        end
    end

    assign bus.oVALID     = v3;
    assign bus.oSPAN_DONE = l3;
    assign bus.oY0_RE = y_re[0];
    assign bus.oY0_IM = y_im[0];
    assign bus.oY1_RE = y_re[1];
    assign bus.oY1_IM = y_im[1];
    assign bus.oY2_RE = y_re[2];
    assign bus.oY2_IM = y_im[2];
    assign bus.oY3_RE = y_re[3];
    assign bus.oY3_IM = y_im[3];
endmodule
